// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU control path: opcodes, sequencer states, PC width.
package cpu_pkg;

    localparam int PC_W = 14;

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_AND   = 5'h02;
    localparam logic [4:0] OP_OR    = 5'h03;
    localparam logic [4:0] OP_XOR   = 5'h04;
    localparam logic [4:0] OP_NOT   = 5'h05;
    localparam logic [4:0] OP_SHL   = 5'h06;
    localparam logic [4:0] OP_SHR   = 5'h07;
    localparam logic [4:0] OP_INC   = 5'h08;
    localparam logic [4:0] OP_DEC   = 5'h09;
    localparam logic [4:0] OP_LOAD  = 5'h0A;
    localparam logic [4:0] OP_STORE = 5'h0B;
    localparam logic [4:0] OP_JMP   = 5'h0D;
    localparam logic [4:0] OP_BEQ   = 5'h0E;
    localparam logic [4:0] OP_BNE   = 5'h0F;
    localparam logic [4:0] OP_CALL  = 5'h10;
    localparam logic [4:0] OP_RET   = 5'h11;
    localparam logic [4:0] OP_HALT  = 5'h1F;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT,
        ST_FAULT
    } state_t;

    // ALU opcodes occupy the contiguous range starting at zero.
    function automatic logic is_alu(input logic [4:0] op);
        return op <= OP_DEC;
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_ret_stack.sv
// Return-address LIFO for CALL/RET; the top entry is visible combinationally on dout.
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] count;
    logic [AW-1:0] top_idx;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = count[AW-1:0] - AW'(1);
    assign dout    = mem[top_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    // Storage is not reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[count[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer: owns the PC, runs the fetch handshake and steps each opcode through its phases.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int PC_W     = cpu_pkg::PC_W
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            load_IR,
    input  logic [4:0]      opcode,
    input  logic [PC_W-1:0] addr_imm,
    input  logic [5:0]      branch_offset,
    input  logic            rs_eq,
    output logic            alu_en,
    output logic            rf_we,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            fault
);

    state_t          state, state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] branch_target;
    logic            rs_push, rs_pop, rs_full, rs_empty;
    logic [PC_W-1:0] rs_dout;

    ret_stack #(
        .DEPTH(RS_DEPTH),
        .W    (PC_W)
    ) u_ret_stack (
        .clk  (clk),
        .rst  (rst),
        .push (rs_push),
        .pop  (rs_pop),
        .din  (pc),
        .dout (rs_dout),
        .full (rs_full),
        .empty(rs_empty)
    );

    // pc already points past the branch, so the offset is relative to the next word.
    assign branch_target = pc + {{(PC_W-6){branch_offset[5]}}, branch_offset};
    assign imem_addr     = pc;
    assign halted        = !rst && (state == ST_HALT);
    assign fault         = !rst && (state == ST_FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Strobes are held low while rst is high so a reset aborts any pending request immediately.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        imem_req   = 1'b0;
        load_IR    = 1'b0;
        alu_en     = 1'b0;
        rf_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rs_push    = 1'b0;
        rs_pop     = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        load_IR    = 1'b1;
                        pc_next    = pc + PC_W'(1);
                        state_next = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_next = ST_FETCH;
                    if (is_alu(opcode)) begin
                        state_next = ST_EXEC;
                    end else begin
                        case (opcode)
                            OP_LOAD, OP_STORE: state_next = ST_MEM;
                            OP_JMP: pc_next = addr_imm;
                            OP_BEQ: if (rs_eq)  pc_next = branch_target;
                            OP_BNE: if (!rs_eq) pc_next = branch_target;
                            OP_CALL: begin
                                if (rs_full) begin
                                    state_next = ST_FAULT;
                                end else begin
                                    rs_push = 1'b1;
                                    pc_next = addr_imm;
                                end
                            end
                            OP_RET: begin
                                if (rs_empty) begin
                                    state_next = ST_FAULT;
                                end else begin
                                    rs_pop  = 1'b1;
                                    pc_next = rs_dout;
                                end
                            end
                            OP_HALT: state_next = ST_HALT;
                            default: state_next = ST_FAULT;
                        endcase
                    end
                end
                ST_EXEC: begin
                    alu_en     = 1'b1;
                    rf_we      = 1'b1;
                    state_next = ST_FETCH;
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode == OP_STORE);
                    if (dmem_ack) begin
                        rf_we      = (opcode == OP_LOAD);
                        state_next = ST_FETCH;
                    end
                end
                ST_HALT, ST_FAULT: state_next = state;
                default: state_next = ST_FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: a small ISA model predicts PC, stack and memory-phase behaviour.
module tb_cpu_seq_ctrl;
    import cpu_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, load_IR;
    logic [13:0] imem_addr, addr_imm, pc;
    logic [4:0]  opcode;
    logic [5:0]  branch_offset;
    logic        rs_eq, alu_en, rf_we, dmem_req, dmem_we, dmem_ack, halted, fault;

    int errors = 0;
    int checks = 0;

    logic [13:0] fetch_q[$];
    logic [1:0]  dmem_q[$];
    logic [13:0] model_stack[$];
    logic [13:0] exp_pc;
    logic        exp_halt, exp_fault;

    cpu_seq_ctrl #(.RS_DEPTH(DEPTH), .PC_W(14)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .load_IR(load_IR), .opcode(opcode), .addr_imm(addr_imm),
        .branch_offset(branch_offset), .rs_eq(rs_eq),
        .alu_en(alu_en), .rf_we(rf_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .pc(pc), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumers: fetch addresses at load_IR, {dmem_we, rf_we} on the data ack cycle.
    always @(negedge clk) begin
        #2;
        if (load_IR === 1'b1) begin
            if (fetch_q.size() == 0) checkOutput("fetch_unexpected", 16'(load_IR), 16'd0);
            else                     checkOutput("fetch_addr", 16'(imem_addr), 16'(fetch_q.pop_front()));
        end
        if (dmem_req === 1'b1 && dmem_ack === 1'b1) begin
            if (dmem_q.size() == 0) checkOutput("dmem_unexpected", 16'(dmem_req), 16'd0);
            else                    checkOutput("dmem_we_rfwe", 16'({dmem_we, rf_we}), 16'(dmem_q.pop_front()));
        end
    end

    task automatic doReset();
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        checkOutput("rst_outputs",
                    16'({imem_req, load_IR, alu_en, rf_we, dmem_req, dmem_we, halted, fault}), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = '0; exp_halt = 1'b0; exp_fault = 1'b0;
        model_stack.delete(); fetch_q.delete(); dmem_q.delete();
        #1;
        checkOutput("rst_pc", 16'(pc), 16'd0);
        checkOutput("rst_imem_req", 16'(imem_req), 16'd1);
    endtask

    task automatic fetchInstr(input logic [4:0] op, input logic [13:0] imm, input logic [5:0] off,
                              input logic eq, input int iwait);
        fetch_q.push_back(exp_pc);
        for (int i = 0; i <= iwait; i++) begin
            imem_ack = (i == iwait); opcode = op; addr_imm = imm; branch_offset = off; rs_eq = eq;
            #1;
            checkOutput("fetch_imem_req", 16'(imem_req), 16'd1);
            checkOutput("fetch_load_IR", 16'(load_IR), 16'(i == iwait));
            @(negedge clk);
        end
        imem_ack = 1'b0;
        exp_pc = exp_pc + 14'd1;
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [13:0] imm, input logic [5:0] off,
                                 input logic eq, input int iwait, input int dwait);
        fetchInstr(op, imm, off, eq, iwait);
        #1;
        checkOutput("decode_idle", 16'({imem_req, load_IR, alu_en, rf_we, dmem_req}), 16'd0);
        if (op <= 5'h09) begin
        end else if (op == OP_LOAD || op == OP_STORE) begin
        end else if (op == OP_JMP) exp_pc = imm;
        else if ((op == OP_BEQ && eq) || (op == OP_BNE && !eq)) exp_pc = exp_pc + {{8{off[5]}}, off};
        else if (op == OP_BEQ || op == OP_BNE) begin
        end else if (op == OP_CALL) begin
            if (model_stack.size() == DEPTH) exp_fault = 1'b1;
            else begin model_stack.push_back(exp_pc); exp_pc = imm; end
        end else if (op == OP_RET) begin
            if (model_stack.size() == 0) exp_fault = 1'b1;
            else exp_pc = model_stack.pop_back();
        end else if (op == OP_HALT) exp_halt = 1'b1;
        else exp_fault = 1'b1;
        @(negedge clk);
        if (op <= 5'h09) begin
            #1;
            checkOutput("exec_strobes", 16'({imem_req, alu_en, rf_we, dmem_req}), 16'b0110);
            @(negedge clk);
        end else if (op == OP_LOAD || op == OP_STORE) begin
            dmem_q.push_back({op == OP_STORE, op == OP_LOAD});
            for (int j = 0; j <= dwait; j++) begin
                dmem_ack = (j == dwait);
                #1;
                checkOutput("mem_req_we", 16'({dmem_req, dmem_we}), 16'({1'b1, op == OP_STORE}));
                checkOutput("mem_rf_we", 16'(rf_we), 16'(op == OP_LOAD && j == dwait));
                @(negedge clk);
            end
            dmem_ack = 1'b0;
        end
        #1;
        checkOutput("post_pc", 16'(pc), 16'(exp_pc));
        checkOutput("post_halt_fault", 16'({halted, fault}), 16'({exp_halt, exp_fault}));
        checkOutput("post_imem_req", 16'(imem_req), 16'(!(exp_halt || exp_fault)));
    endtask

    task automatic checkStuck();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            imem_ack = 1'b1; dmem_ack = 1'b1;
            #1;
            checkOutput("stuck_strobes", 16'({imem_req, load_IR, alu_en, rf_we, dmem_req}), 16'd0);
            checkOutput("stuck_pc", 16'(pc), 16'(exp_pc));
            checkOutput("stuck_flags", 16'({halted, fault}), 16'({exp_halt, exp_fault}));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; opcode = '0; addr_imm = '0;
        branch_offset = '0; rs_eq = 1'b0;
        exp_pc = '0; exp_halt = 1'b0; exp_fault = 1'b0;
        @(negedge clk);
        doReset();

        applyStimulus(OP_ADD, 14'h0, 6'h0, 1'b0, 0, 0);
        applyStimulus(OP_OR,  14'h0, 6'h0, 1'b0, 3, 0);

        applyStimulus(OP_JMP, 14'h0010, 6'h0, 1'b0, 0, 0);
        applyStimulus(OP_BEQ, 14'h0, 6'b111100, 1'b1, 0, 0);
        applyStimulus(OP_JMP, 14'h0010, 6'h0, 1'b0, 1, 0);
        applyStimulus(OP_BEQ, 14'h0, 6'b111100, 1'b0, 0, 0);
        applyStimulus(OP_JMP, 14'h0010, 6'h0, 1'b0, 0, 0);
        applyStimulus(OP_BNE, 14'h0, 6'b111100, 1'b0, 0, 0);
        applyStimulus(OP_JMP, 14'h3FFF, 6'h0, 1'b0, 0, 0);
        applyStimulus(OP_BEQ, 14'h0, 6'b000001, 1'b1, 0, 0);

        applyStimulus(OP_LOAD,  14'h0, 6'h0, 1'b0, 1, 2);
        applyStimulus(OP_STORE, 14'h0, 6'h0, 1'b0, 0, 0);

        for (int i = 0; i < 9; i++) applyStimulus(OP_CALL, 14'(14'h0100 + i * 14'h20), 6'h0, 1'b0, 0, 0);
        checkStuck();
        doReset();

        applyStimulus(OP_RET, 14'h0, 6'h0, 1'b0, 0, 0);
        doReset();

        for (int i = 0; i < 8; i++) applyStimulus(OP_CALL, 14'(14'h0200 + i * 14'h40), 6'h0, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(OP_RET, 14'h0, 6'h0, 1'b0, i % 2, 0);

        applyStimulus(5'h0C, 14'h0, 6'h0, 1'b0, 0, 0);
        checkStuck();
        doReset();

        applyStimulus(OP_HALT, 14'h0, 6'h0, 1'b0, 0, 0);
        checkStuck();
        doReset();

        applyStimulus(OP_JMP, 14'h0123, 6'h0, 1'b0, 0, 0);
        fetchInstr(OP_LOAD, 14'h0, 6'h0, 1'b0, 0);
        @(negedge clk);
        #1;
        checkOutput("midmem_dmem_req", 16'(dmem_req), 16'd1);
        doReset();
        applyStimulus(OP_XOR, 14'h0, 6'h0, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle control sequencer for the 19-bit CPU. It owns the program counter and drives the instruction-memory fetch handshake. It also generates `load_IR` for the instruction register and, from the decoded 5-bit opcode, steps each instruction through its execute or memory phases. It sits between instruction memory, the instruction register, the register file/ALU and data memory, and holds an internal return-address stack for CALL/RET.

## Interface
- `RS_DEPTH`, 8: return-stack entries (power of two, ≥2)
- `PC_W`, 14: PC / address width (fixed to match `addr_imm`)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  instruction fetch request
- `imem_addr`  out  PC_W  fetch address (= `pc`)
- `imem_ack`  in  1  instruction word valid this cycle
- `load_IR`  out  1  IR capture strobe
- `opcode`  in  5  from IR
- `addr_imm`  in  PC_W  from IR (JMP/CALL target)
- `branch_offset`  in  6  from IR, two's complement
- `rs_eq`  in  1  register-file compare, rs1 == rs2
- `alu_en`  out  1  ALU operation strobe
- `rf_we`  out  1  register-file write enable
- `dmem_req`  out  1  data-memory request
- `dmem_we`  out  1  1 = STORE, 0 = LOAD; valid with `dmem_req`
- `dmem_ack`  in  1  data access complete
- `pc`  out  PC_W  current program counter
- `halted`  out  1  HALT executed
- `fault`  out  1  illegal opcode or return-stack over/underflow

## Operation
- States: FETCH, DECODE, EXEC, MEM, HALT, FAULT.
- FETCH:
  - `imem_req`=1; hold until `imem_ack`.
  - On the ack cycle: `load_IR`=1, `pc`<=`pc`+1 (mod 2^14), next state DECODE.
- DECODE (IR holds the new word):
  - 0x00–0x09 (ALU) -> EXEC.
  - 0x0A LOAD / 0x0B STORE -> MEM.
  - 0x0D JMP: `pc`<=`addr_imm` -> FETCH.
  - 0x0E BEQ / 0x0F BNE: if taken (`rs_eq`=1 for BEQ, 0 for BNE), `pc`<=`pc`+sext(`branch_offset`) mod 2^14, so the offset is relative to the already-incremented PC. Next state FETCH whether or not the branch is taken.
  - 0x10 CALL: push `pc` (the return address), `pc`<=`addr_imm` -> FETCH. If the stack is full -> FAULT, and neither push nor PC change happens.
  - 0x11 RET: pop into `pc` -> FETCH. If the stack is empty -> FAULT.
  - 0x1F -> HALT.
  - All other opcodes (0x0C, 0x12–0x1E) -> FAULT.
- EXEC: `alu_en`=1, `rf_we`=1 for exactly one cycle -> FETCH.
- MEM:
  - `dmem_req`=1 and `dmem_we`=(opcode==0x0B); both held until `dmem_ack`.
  - On the ack cycle, LOAD also asserts `rf_we`=1. Next state FETCH.
- HALT and FAULT are sticky until `rst`. Their outputs: `halted`=1 or `fault`=1, all strobes 0, `pc` frozen.
- Return stack: LIFO of `RS_DEPTH` × PC_W with a count 0..`RS_DEPTH`. Full is count==`RS_DEPTH`; empty is count==0. A push and a pop never occur in the same cycle.

## Timing
- Reset values:
  - state FETCH, `pc`=0, stack count 0.
  - All strobes 0 (`imem_req`, `load_IR`, `alu_en`, `rf_we`, `dmem_req`, `dmem_we`); `halted`=0, `fault`=0.
  - `imem_req` rises in the first cycle after `rst` deasserts.
- All strobes are Moore/Mealy outputs of the current state and inputs, not registered copies. `load_IR` is high in the same cycle as `imem_ack`.
- Minimum latency with zero-wait memories (ack in the first request cycle):
  - JMP / branch / CALL / RET: 2 cycles.
  - ALU: 3 cycles.
  - LOAD / STORE: 3 cycles.
- Each memory wait cycle adds 1 cycle. `imem_ack` or `dmem_ack` seen outside its request state is ignored.
- `rst` mid-instruction, including during a pending `imem_req` or `dmem_req`, aborts at the next edge. The request drops, and pending memory transactions are the memory's responsibility.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams (OP_ADD..OP_RET, OP_HALT=5'h1F)
  - state enum
  - PC_W
  - `is_alu(op)` helper
- Sub-module `ret_stack`: synchronous LIFO with push, pop, data in/out, full, empty, and reset to empty.
- The remainder is the FSM and the PC register.

## Test plan
- Zero-wait fetch of ALU 0x00 at pc 0 -> `load_IR` at cycle 0, `alu_en`/`rf_we` at cycle 2, `pc`=1, `imem_req` again at cycle 3.
- `imem_ack` delayed 3 cycles -> `imem_req` held 4 cycles, single `load_IR`, `pc` increments once.
- BEQ at pc 0x0010, offset 6'b111100, `rs_eq`=1 -> `pc`=0x000D. Same word with `rs_eq`=0 -> `pc`=0x0011. Branch from pc 0x3FFF with offset +1 -> wraps to 0x0001.
- LOAD with `dmem_ack` after 2 cycles -> `dmem_req`=1 and `dmem_we`=0 for 3 cycles, `rf_we` only on the ack cycle. STORE -> `dmem_we`=1 and `rf_we` never asserted.
- Nine nested CALLs with `RS_DEPTH`=8 -> 9th asserts `fault` and `pc` holds. Separately, RET with an empty stack -> `fault`. Eight CALLs followed by eight RETs -> return addresses come back in LIFO order.
- Opcode 0x0C -> `fault`; opcode 0x1F -> `halted`, no further `imem_req`. `rst` asserted in either state, or mid-MEM -> `pc`=0, all strobes 0, fetch resumes.
